sterownik_wyjsc: RTL and testbench
==================================

# sterownik_wyjsc

Output-refresh controller for the PLC's physical output bank. It holds an 8-byte output image written by the CPU core and tracks which bytes have changed. On each end-of-scan refresh request it walks the changed bytes in ascending order and drives the output demultiplexer's select, data and write-strobe lines with a safe setup/strobe/hold sequence. It is the only master of the demultiplexer, sitting between the CPU write path and the output demux.

## Interface
- `ZAPIS_SZER`, default 1: width of the `dmx_zapis` strobe in clock cycles, range 1..15.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `wr_en`  in  1  CPU write strobe into the output image (one byte per cycle).
- `wr_adr`  in  3  image byte index for the write.
- `wr_dane`  in  8  image byte data.
- `odswiez`  in  1  refresh request pulse (end of PLC scan).
- `pelne`  in  1  sampled with an accepted `odswiez`; forces all 8 bytes dirty (full refresh).
- `rd_adr`  in  3  read-back index.
- `rd_dane`  out  8  combinational read of image byte `rd_adr`.
- `dmx_sel`  out  3  demux select, registered.
- `dmx_dane`  out  8  demux data, registered snapshot.
- `dmx_zapis`  out  1  demux write strobe, registered.
- `zajety`  out  1  high whenever the FSM is not in IDLE.
- `gotowe`  out  1  one-cycle pulse when a refresh pass completes.
- `brudne`  out  8  dirty-bit vector, bit i = image byte i not yet transferred.

## Operation
- Reset values:
  - image = 8'h00, `brudne` = 8'hFF, so the first refresh drives zeros to every output.
  - `dmx_sel` = 0, `dmx_dane` = 0, `dmx_zapis` = 0, `gotowe` = 0, pending = 0, state = IDLE.
- CPU write: image[wr_adr] <= wr_dane and brudne[wr_adr] <= 1. Writes are accepted in every state.
- FSM states:
  - IDLE: on `odswiez`, if `pelne`, brudne |= 8'hFF. Next state:
    - SETUP at the lowest dirty index, if any bit of the updated vector is set;
    - otherwise KONIEC.
  - SETUP (1 cycle):
    - `dmx_sel` = idx, `dmx_dane` = image[idx] snapshot, `dmx_zapis` = 0;
    - brudne[idx] cleared at entry.
  - STROBE (`ZAPIS_SZER` cycles): `dmx_zapis` = 1; sel and data held.
  - HOLD (1 cycle): `dmx_zapis` = 0; sel and data held. The demux also captures on the falling edge of the strobe, so this hold is mandatory. Next state:
    - SETUP at the lowest dirty index greater than idx, if one exists;
    - otherwise KONIEC.
  - KONIEC (1 cycle): `gotowe` = 1. Then SETUP/KONIEC again if pending is set (pending cleared); otherwise IDLE.
- A single pass never wraps. Bytes whose index is at or below the current idx and that are re-dirtied mid-pass stay dirty for the next pass.
- `odswiez` outside IDLE sets pending (1-deep; further requests merge). `pelne` with a pending request is OR-latched and applied at the restart.
- Write to idx in the same cycle its dirty bit is cleared at SETUP entry: the write wins. The bit stays set, and the snapshot holds the old value. The new value goes out on the next pass.
- `dmx_*` outputs keep their last values in IDLE/KONIEC.

## Timing
- Per transferred byte: 2 + `ZAPIS_SZER` cycles.
- `odswiez` accepted at edge 0:
  - first SETUP in cycle 1;
  - KONIEC in cycle 1 + n·(2+`ZAPIS_SZER`) for n transferred bytes;
  - with no dirty bytes, KONIEC (and `gotowe`) in cycle 1.
- `rd_dane` is combinational. A write is visible on `rd_dane` the cycle after its edge.
- `rst` asserted mid-pass: the next cycle shows reset values, so `dmx_zapis` drops immediately. A pending request is discarded.

## Structure
- Shared package `sterownik_wyjsc_pkg` holds:
  - state encoding constants (IDLE, SETUP, STROBE, HOLD, KONIEC);
  - width constants (index width 3, data width 8, strobe counter width 4).
- Sub-module `koder_priorytetowy`: combinational lowest-set-bit finder over an 8-bit mask. It takes a start index and exclusive/inclusive select, and returns a found flag plus a 3-bit index. It is used by IDLE and HOLD.
- The strobe-width counter and pending flag live in the top level.

## Test plan
- Reset, then `odswiez`: 8 transfers with sel 0..7 and data 0x00, `dmx_zapis` high in cycles 2,5,…,23, `gotowe` in cycle 25, then `brudne` = 0.
- Write adr 5 = 0xA5 and adr 2 = 0x3C after a clean pass, then `odswiez`: transfer sel 2/0x3C, then sel 5/0xA5, `gotowe` in cycle 7.
- `odswiez` with `brudne` = 0: `gotowe` in cycle 1, `zajety` high exactly one cycle, no `dmx_zapis`.
- During the STROBE of idx 2, write adr 1 = 0x11 and adr 6 = 0x66: idx 6 is transferred in this pass, and `brudne` = 8'h02 after `gotowe`.
- `odswiez` plus `pelne` issued while busy: `gotowe`, then the next cycle SETUP idx 0, and all 8 bytes are transferred again.
- `rst` in the second STROBE cycle with `ZAPIS_SZER` = 3: the next cycle has `dmx_zapis` = 0, `zajety` = 0 and `brudne` = 8'hFF.

Source files
------------

// File: rtl/sterownik_wyjsc_pkg.sv
// Shared types and widths for the output-refresh controller.
//   stan_t        : FSM state encoding
//   ADR_W, DANE_W : image index / byte widths
//   LICZ_W        : strobe-width counter width
//   N_BAJTOW      : number of bytes in the output image
package sterownik_wyjsc_pkg;

   localparam int unsigned ADR_W    = 3;
   localparam int unsigned DANE_W   = 8;
   localparam int unsigned LICZ_W   = 4;
   localparam int unsigned N_BAJTOW = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      KONIEC = 3'd4
   } stan_t;

endpackage

// File: rtl/sterownik_wyjsc_if.sv
// CPU write path, refresh request, read-back and output-demux lines of the
// output-refresh controller.
//   slave  : the controller side (sterownik_wyjsc)
//   master : the CPU / scan-engine side
interface sterownik_wyjsc_if;
   import sterownik_wyjsc_pkg::*;

   logic                wr_en;
   logic [ADR_W-1:0]    wr_adr;
   logic [DANE_W-1:0]   wr_dane;
   logic                odswiez;
   logic                pelne;
   logic [ADR_W-1:0]    rd_adr;
   logic [DANE_W-1:0]   rd_dane;
   logic [ADR_W-1:0]    dmx_sel;
   logic [DANE_W-1:0]   dmx_dane;
   logic                dmx_zapis;
   logic                zajety;
   logic                gotowe;
   logic [N_BAJTOW-1:0] brudne;

   modport slave (
      input  wr_en, wr_adr, wr_dane, odswiez, pelne, rd_adr,
      output rd_dane, dmx_sel, dmx_dane, dmx_zapis, zajety, gotowe, brudne
   );

   modport master (
      output wr_en, wr_adr, wr_dane, odswiez, pelne, rd_adr,
      input  rd_dane, dmx_sel, dmx_dane, dmx_zapis, zajety, gotowe, brudne
   );

endinterface

// File: rtl/sterownik_wyjsc_koder_priorytetowy.sv
// Lowest-set-bit finder over the dirty mask, searching upward from a start
// index (inclusive or exclusive of the start itself).
//   maska       : candidate bits
//   start       : first index to consider
//   wlacznie    : 1 = start itself is eligible, 0 = only indices above start
//   znaleziony_c: a candidate exists
//   indeks_c    : lowest eligible set index (0 when none)
module koder_priorytetowy
   import sterownik_wyjsc_pkg::*;
(
   input  logic [N_BAJTOW-1:0] maska,
   input  logic [ADR_W-1:0]    start,
   input  logic                wlacznie,
   output logic                znaleziony_c,
   output logic [ADR_W-1:0]    indeks_c
);

   // Scan downward so the last hit written is the lowest eligible index.
   always_comb begin
      znaleziony_c = 1'b0;
      indeks_c     = '0;
      for (int i = N_BAJTOW - 1; i >= 0; i--) begin
         if (maska[i] && ((i > int'(start)) || (wlacznie && (i == int'(start))))) begin
            znaleziony_c = 1'b1;
            indeks_c     = ADR_W'(i);
         end
      end
   end

endmodule

// File: rtl/sterownik_wyjsc.sv
// Output-refresh controller: holds the 8-byte output image, tracks dirty
// bytes and, on each refresh request, walks the dirty bytes in ascending
// order driving the output demux with a setup / strobe / hold sequence.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : CPU write port, refresh request, read-back, demux outputs
//   ZAPIS_SZER : dmx_zapis strobe width in cycles (1..15)
module sterownik_wyjsc
   import sterownik_wyjsc_pkg::*;
#(
   parameter int unsigned ZAPIS_SZER = 1
)
(
   input  logic           clk,
   input  logic           rst,
   sterownik_wyjsc_if.slave bus
);

   localparam logic [LICZ_W-1:0] SZER_M1 = LICZ_W'(ZAPIS_SZER - 1);

   stan_t               stan;
   logic [DANE_W-1:0]   obraz [N_BAJTOW];
   logic [N_BAJTOW-1:0] brudne_q;
   logic [N_BAJTOW-1:0] brudne_d;
   logic [ADR_W-1:0]    sel_q;
   logic [DANE_W-1:0]   dane_q;
   logic                zapis_q;
   logic                gotowe_q;
   logic                oczek_q;
   logic                oczek_pelne_q;
   logic [LICZ_W-1:0]   licz_q;

   logic                akcept_c;
   logic                pelne_c;
   logic                laduj_c;
   logic [N_BAJTOW-1:0] enc_maska;
   logic [ADR_W-1:0]    enc_start;
   logic                enc_wl;
   logic                znal_c;
   logic [ADR_W-1:0]    idx_c;

   koder_priorytetowy u_koder (
      .maska        (enc_maska),
      .start        (enc_start),
      .wlacznie     (enc_wl),
      .znaleziony_c (znal_c),
      .indeks_c     (idx_c)
   );

   // Pass start/restart decision, encoder inputs and next dirty vector.
   // A request arriving during KONIEC merges with the pending one.
   always_comb begin
      akcept_c  = 1'b0;
      pelne_c   = 1'b0;
      enc_start = '0;
      enc_wl    = 1'b1;
      enc_maska = '0;
      laduj_c   = 1'b0;
      brudne_d  = brudne_q;

      case (stan)
         IDLE: begin
            akcept_c = bus.odswiez;
            pelne_c  = bus.odswiez & bus.pelne;
         end
         KONIEC: begin
            akcept_c = oczek_q | bus.odswiez;
            pelne_c  = oczek_pelne_q | (bus.odswiez & bus.pelne);
         end
         HOLD: begin
            enc_start = sel_q;
            enc_wl    = 1'b0;
         end
         default: ;
      endcase

      enc_maska = brudne_q | {N_BAJTOW{pelne_c}};
      laduj_c   = ((stan == HOLD) || akcept_c) && znal_c;

      // Full-refresh OR, then clear of the byte being loaded; a CPU write
      // to the same byte wins so the new value goes out next pass.
      brudne_d = enc_maska;
      if (laduj_c)
         brudne_d[idx_c] = 1'b0;
      if (bus.wr_en)
         brudne_d[bus.wr_adr] = 1'b1;
   end

   // Image, dirty bits, pending request and the refresh FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         stan          <= IDLE;
         brudne_q      <= '1;
         sel_q         <= '0;
         dane_q        <= '0;
         zapis_q       <= 1'b0;
         gotowe_q      <= 1'b0;
         oczek_q       <= 1'b0;
         oczek_pelne_q <= 1'b0;
         licz_q        <= '0;
         for (int i = 0; i < int'(N_BAJTOW); i++)
            obraz[i] <= '0;
      end else begin
         brudne_q <= brudne_d;
         gotowe_q <= 1'b0;

         if (bus.wr_en)
            obraz[bus.wr_adr] <= bus.wr_dane;

         // Snapshot is taken from the image before any same-cycle write.
         if (laduj_c) begin
            sel_q  <= idx_c;
            dane_q <= obraz[idx_c];
         end

         if (bus.odswiez && ((stan == SETUP) || (stan == STROBE) || (stan == HOLD))) begin
            oczek_q       <= 1'b1;
            oczek_pelne_q <= oczek_pelne_q | bus.pelne;
         end

         case (stan)
            IDLE, KONIEC: begin
               if (akcept_c) begin
                  oczek_q       <= 1'b0;
                  oczek_pelne_q <= 1'b0;
                  if (znal_c) begin
                     stan <= SETUP;
                  end else begin
                     stan     <= KONIEC;
                     gotowe_q <= 1'b1;
                  end
               end else begin
                  stan <= IDLE;
               end
            end
            SETUP: begin
               stan    <= STROBE;
               zapis_q <= 1'b1;
               licz_q  <= SZER_M1;
            end
            STROBE: begin
               if (licz_q == '0) begin
                  stan    <= HOLD;
                  zapis_q <= 1'b0;
               end else begin
                  licz_q <= licz_q - LICZ_W'(1);
               end
            end
            HOLD: begin
               if (znal_c) begin
                  stan <= SETUP;
               end else begin
                  stan     <= KONIEC;
                  gotowe_q <= 1'b1;
               end
            end
            default: stan <= IDLE;
         endcase
      end
   end

   assign bus.rd_dane   = obraz[bus.rd_adr];
   assign bus.dmx_sel   = sel_q;
   assign bus.dmx_dane  = dane_q;
   assign bus.dmx_zapis = zapis_q;
   assign bus.gotowe    = gotowe_q;
   assign bus.brudne    = brudne_q;
   assign bus.zajety    = (stan != IDLE);

endmodule

// File: tb/tb_sterownik_wyjsc.sv
// Scoreboard bench for sterownik_wyjsc: one instance with a 1-cycle strobe
// exercised through full, partial, empty and mid-pass refresh passes, and
// one with a 3-cycle strobe used for the mid-strobe reset case.
module tb_sterownik_wyjsc;
   import sterownik_wyjsc_pkg::*;

   logic clk   = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   always #5 clk = ~clk;

   sterownik_wyjsc_if bus_a ();
   sterownik_wyjsc_if bus_b ();

   sterownik_wyjsc #(.ZAPIS_SZER(1)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
   sterownik_wyjsc #(.ZAPIS_SZER(3)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         done;
      int         cyc;
      logic [2:0] sel;
      logic [7:0] dane;
      logic [7:0] brudne;
   } zdarz_t;

   zdarz_t oczek[$];
   logic   zap_prev = 1'b0;

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Pop the next expected event and compare against what dut_a shows now.
   task automatic zdarzenie(input bit done);
      zdarz_t e;
      checks++;
      if (oczek.size() == 0) begin
         errors++;
         $display("FAIL event: unexpected %s at cycle %0d sel=%0d dane=%h",
                  done ? "gotowe" : "strobe", cyc, bus_a.dmx_sel, bus_a.dmx_dane);
         return;
      end
      e = oczek.pop_front();
      if (e.done != done || e.cyc != cyc ||
          (!done && (bus_a.dmx_sel !== e.sel || bus_a.dmx_dane !== e.dane)) ||
          (done && bus_a.brudne !== e.brudne)) begin
         errors++;
         $display("FAIL event: got gotowe=%0d cyc=%0d sel=%0d dane=%h brudne=%h, expected gotowe=%0d cyc=%0d sel=%0d dane=%h brudne=%h",
                  done, cyc, bus_a.dmx_sel, bus_a.dmx_dane, bus_a.brudne,
                  e.done, e.cyc, e.sel, e.dane, e.brudne);
      end
   endtask

   // Monitor: rising edge of the strobe is a transfer, gotowe ends a pass.
   always @(negedge clk) begin
      if (bus_a.dmx_zapis === 1'b1 && zap_prev !== 1'b1)
         zdarzenie(1'b0);
      if (bus_a.gotowe === 1'b1)
         zdarzenie(1'b1);
      zap_prev <= bus_a.dmx_zapis;
   end

   // Cycle k of a pass (k = 1 is the first SETUP) as seen by the monitor.
   function automatic int cy(input int t0, input int k);
      return t0 + k - 1;
   endfunction

   task automatic push_xfer(input int c, input logic [2:0] s, input logic [7:0] d);
      zdarz_t e;
      e.done = 1'b0; e.cyc = c; e.sel = s; e.dane = d; e.brudne = 8'h00;
      oczek.push_back(e);
   endtask

   task automatic push_done(input int c, input logic [7:0] b);
      zdarz_t e;
      e.done = 1'b1; e.cyc = c; e.sel = 3'd0; e.dane = 8'h00; e.brudne = b;
      oczek.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic zapisz(input logic [2:0] adr, input logic [7:0] d);
      bus_a.wr_en   = 1'b1;
      bus_a.wr_adr  = adr;
      bus_a.wr_dane = d;
      tick();
      bus_a.wr_en   = 1'b0;
   endtask

   // Returns the edge count of the accepting edge (edge 0 of the pass).
   task automatic odswiez_a(input bit p, output int t0);
      t0            = cyc + 1;
      bus_a.odswiez = 1'b1;
      bus_a.pelne   = p;
      tick();
      bus_a.odswiez = 1'b0;
      bus_a.pelne   = 1'b0;
   endtask

   task automatic wait_idle_a(input string name);
      int n = 0;
      while (bus_a.zajety === 1'b1 && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (bus_a.zajety !== 1'b0) begin
         errors++;
         $display("FAIL %s: zajety still %b after %0d cycles", name, bus_a.zajety, n);
      end
      tick();
      tick();
   endtask

   logic [7:0] obraz_exp [8];

   initial begin
      int t0;
      int nz;

      bus_a.wr_en = 1'b0; bus_a.wr_adr = '0; bus_a.wr_dane = '0;
      bus_a.odswiez = 1'b0; bus_a.pelne = 1'b0; bus_a.rd_adr = 3'd3;
      bus_b.wr_en = 1'b0; bus_b.wr_adr = '0; bus_b.wr_dane = '0;
      bus_b.odswiez = 1'b0; bus_b.pelne = 1'b0; bus_b.rd_adr = '0;

      tick();
      tick();
      rst_a = 1'b0;
      rst_b = 1'b0;

      // Reset values.
      chk8("reset dmx_sel",   8'(bus_a.dmx_sel),   8'h00);
      chk8("reset dmx_dane",  bus_a.dmx_dane,      8'h00);
      chk8("reset dmx_zapis", 8'(bus_a.dmx_zapis), 8'h00);
      chk8("reset gotowe",    8'(bus_a.gotowe),    8'h00);
      chk8("reset zajety",    8'(bus_a.zajety),    8'h00);
      chk8("reset brudne",    bus_a.brudne,        8'hFF);
      chk8("reset rd_dane",   bus_a.rd_dane,       8'h00);

      // First pass after reset: all eight bytes of zeros.
      odswiez_a(1'b0, t0);
      for (int i = 0; i < 8; i++)
         push_xfer(cy(t0, 2 + 3 * i), 3'(i), 8'h00);
      push_done(cy(t0, 25), 8'h00);
      wait_idle_a("full pass");
      chk8("brudne after full pass", bus_a.brudne, 8'h00);

      // Two writes, transferred in ascending index order.
      zapisz(3'd5, 8'hA5);
      bus_a.rd_adr = 3'd5;
      #1;
      chk8("rd_dane after write", bus_a.rd_dane, 8'hA5);
      zapisz(3'd2, 8'h3C);
      chk8("brudne after writes", bus_a.brudne, 8'h24);
      odswiez_a(1'b0, t0);
      push_xfer(cy(t0, 2), 3'd2, 8'h3C);
      push_xfer(cy(t0, 5), 3'd5, 8'hA5);
      push_done(cy(t0, 7), 8'h00);
      wait_idle_a("two-byte pass");

      // Nothing dirty: gotowe in cycle 1, busy for exactly one cycle.
      odswiez_a(1'b0, t0);
      push_done(cy(t0, 1), 8'h00);
      nz = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus_a.zajety === 1'b1) nz++;
         tick();
      end
      chk8("empty pass zajety cycles", 8'(nz), 8'd1);
      wait_idle_a("empty pass");

      // Writes during the strobe of idx 2: idx 6 joins this pass, idx 1 waits.
      zapisz(3'd2, 8'h22);
      zapisz(3'd4, 8'h44);
      odswiez_a(1'b0, t0);
      push_xfer(cy(t0, 2),  3'd2, 8'h22);
      push_xfer(cy(t0, 5),  3'd4, 8'h44);
      push_xfer(cy(t0, 8),  3'd6, 8'h66);
      push_done(cy(t0, 10), 8'h02);
      tick();
      zapisz(3'd6, 8'h66);
      zapisz(3'd1, 8'h11);
      wait_idle_a("mid-pass writes");
      chk8("brudne after mid-pass writes", bus_a.brudne, 8'h02);

      // Full refresh requested while busy: restart right after gotowe.
      obraz_exp[0] = 8'h00; obraz_exp[1] = 8'h11; obraz_exp[2] = 8'h22; obraz_exp[3] = 8'h00;
      obraz_exp[4] = 8'h44; obraz_exp[5] = 8'hA5; obraz_exp[6] = 8'h66; obraz_exp[7] = 8'h00;
      odswiez_a(1'b0, t0);
      push_xfer(cy(t0, 2), 3'd1, 8'h11);
      push_done(cy(t0, 4), 8'h00);
      for (int i = 0; i < 8; i++)
         push_xfer(cy(t0, 6 + 3 * i), 3'(i), obraz_exp[i]);
      push_done(cy(t0, 29), 8'h00);
      bus_a.odswiez = 1'b1;
      bus_a.pelne   = 1'b1;
      tick();
      bus_a.odswiez = 1'b0;
      bus_a.pelne   = 1'b0;
      wait_idle_a("pending full pass");
      chk8("brudne after pending pass", bus_a.brudne, 8'h00);
      chk8("scoreboard drained", 8'(oczek.size()), 8'd0);

      // Reset in the second strobe cycle (3-cycle strobe), with a pending request.
      bus_b.odswiez = 1'b1;
      tick();                       // cycle 1: SETUP idx 0
      chk8("b setup brudne", bus_b.brudne, 8'hFE);
      tick();                       // cycle 2: first strobe cycle, request goes pending
      bus_b.odswiez = 1'b0;
      chk8("b strobe zapis", 8'(bus_b.dmx_zapis), 8'h01);
      tick();                       // cycle 3: second strobe cycle
      chk8("b strobe2 zapis", 8'(bus_b.dmx_zapis), 8'h01);
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      chk8("b reset zapis",  8'(bus_b.dmx_zapis), 8'h00);
      chk8("b reset zajety", 8'(bus_b.zajety),    8'h00);
      chk8("b reset brudne", bus_b.brudne,        8'hFF);
      tick();
      tick();
      chk8("b pending discarded", 8'(bus_b.zajety), 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
